// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared MIPS-subset constants and the fetch FSM state type.
//   HALT_OPCODE  - instr[31:26] value that stops fetch
//   OPCODE_*     - control-flow opcodes, for decode-side users of this package
//   WORD_BYTES   - PC increment per sequential fetch
//   fsm_state_t  - RUN / HALTED
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  localparam logic [5:0] HALT_OPCODE = 6'b111111;
  localparam logic [5:0] OPCODE_BEQ  = 6'b000100;
  localparam logic [5:0] OPCODE_BNE  = 6'b000101;
  localparam logic [5:0] OPCODE_J    = 6'b000010;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Groups the instruction-memory bus, the fetch->decode handshake, the
// execute redirect inputs and the status outputs of the fetch unit.
//   master : the fetch unit (drives imem_addr, if_*, halted, misaligned,
//            fetch_count; samples everything else)
//   slave  : the surrounding pipeline / memory / testbench
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        id_ready;
  logic        br_valid;
  logic        branch_eq;
  logic        branch_ne;
  logic        alu_zero;
  logic [31:0] br_pc_plus4;
  logic [15:0] br_imm16;
  logic        jump;
  logic [25:0] jump_target26;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, if_instr, if_pc_plus4, if_valid,
           halted, misaligned, fetch_count,
    input  imem_rdata, id_ready, br_valid, branch_eq, branch_ne,
           alu_zero, br_pc_plus4, br_imm16, jump, jump_target26
  );

  modport slave (
    input  imem_addr, if_instr, if_pc_plus4, if_valid,
           halted, misaligned, fetch_count,
    output imem_rdata, id_ready, br_valid, branch_eq, branch_ne,
           alu_zero, br_pc_plus4, br_imm16, jump, jump_target26
  );

endinterface

// File: rtl/instruction_fetch_unit_pc_target_calc.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pc_target_calc
// Combinational redirect decode for the fetch unit.
//   i_jump, i_br_valid, i_branch_eq, i_branch_ne, i_alu_zero : redirect cause
//   i_br_pc_plus4 : PC+4 of the branch/jump instruction
//   i_br_imm16    : branch offset in words (signed)
//   i_jump_target26 : jump index field
//   o_take        : a redirect happens this cycle
//   o_target      : word-aligned redirect address
//   o_misaligned  : taken redirect whose base PC had nonzero low bits
// ---------------------------------------------------------------------------
module instruction_fetch_unit_pc_target_calc (
  input  logic        i_jump,
  input  logic        i_br_valid,
  input  logic        i_branch_eq,
  input  logic        i_branch_ne,
  input  logic        i_alu_zero,
  input  logic [31:0] i_br_pc_plus4,
  input  logic [15:0] i_br_imm16,
  input  logic [25:0] i_jump_target26,
  output logic        o_take,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic signed [31:0] w_br_off;
  logic        [31:0] w_br_target;
  logic        [31:0] w_j_target;
  logic        [31:0] w_raw_target;

  // Both condition terms are ORed, so beq+bne together always takes.
  assign o_take = i_jump |
                  (i_br_valid & ((i_branch_eq & i_alu_zero) |
                                 (i_branch_ne & ~i_alu_zero)));

  assign w_br_off     = {{14{i_br_imm16[15]}}, i_br_imm16, 2'b00};
  assign w_br_target  = i_br_pc_plus4 + $unsigned(w_br_off);
  assign w_j_target   = {i_br_pc_plus4[31:28], i_jump_target26, 2'b00};
  assign w_raw_target = i_jump ? w_j_target : w_br_target;

  assign o_target     = {w_raw_target[31:2], 2'b00};
  assign o_misaligned = o_take & (i_br_pc_plus4[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the PC, addresses a combinational instruction memory, registers the
// returned word and hands it to decode over if_valid/id_ready. Execute can
// redirect (branch/jump), which flushes the fetched slot. A halt opcode
// freezes the PC until the next redirect.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instruction_fetch_unit_if.master (memory bus, decode
//                handshake, redirect inputs, status outputs)
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = instruction_fetch_unit_pkg::HALT_OPCODE
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  logic        w_take;
  logic [31:0] w_target;
  logic        w_mis;
  logic        w_load;
  logic [31:0] w_pc_next_seq;

  fsm_state_t  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr_p1;
  logic [31:0] r_pc_plus4_p1;
  logic        r_vld_p1;
  logic        r_halted;
  logic        r_misaligned;
  logic [31:0] r_fetch_count;

  instruction_fetch_unit_pc_target_calc u_target (
    .i_jump          (bus.jump),
    .i_br_valid      (bus.br_valid),
    .i_branch_eq     (bus.branch_eq),
    .i_branch_ne     (bus.branch_ne),
    .i_alu_zero      (bus.alu_zero),
    .i_br_pc_plus4   (bus.br_pc_plus4),
    .i_br_imm16      (bus.br_imm16),
    .i_jump_target26 (bus.jump_target26),
    .o_take          (w_take),
    .o_target        (w_target),
    .o_misaligned    (w_mis)
  );

  assign w_pc_next_seq = r_pc + 32'(WORD_BYTES);
  assign w_load        = (r_state == RUN) && (!r_vld_p1 || bus.id_ready);

  // ---- p0 -> p1: PC/memory word into the fetch slot ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_instr_p1    <= '0;
      r_pc_plus4_p1 <= '0;
      r_vld_p1      <= 1'b0;
      r_halted      <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      // Handshake is counted even on a redirect edge that flushes the slot.
      if (r_vld_p1 && bus.id_ready) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      if (w_take) begin
        r_pc     <= w_target;
        r_vld_p1 <= 1'b0;
        r_state  <= RUN;
        r_halted <= 1'b0;
        if (w_mis) begin
          r_misaligned <= 1'b1;
        end
      end else if (w_load) begin
        if (bus.imem_rdata[31:26] == HALT_OPCODE) begin
          // Halt word is dropped; PC stays on it so a restart is visible.
          r_vld_p1 <= 1'b0;
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end else begin
          r_instr_p1    <= bus.imem_rdata;
          r_pc_plus4_p1 <= w_pc_next_seq;
          r_vld_p1      <= 1'b1;
          r_pc          <= w_pc_next_seq;
        end
      end
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.if_instr    = r_instr_p1;
  assign bus.if_pc_plus4 = r_pc_plus4_p1;
  assign bus.if_valid    = r_vld_p1;
  assign bus.halted      = r_halted;
  assign bus.misaligned  = r_misaligned;
  assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] mem [0:63];

  instruction_fetch_unit_if ifc ();

  instruction_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'b111111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifc.imem_rdata = mem[ifc.imem_addr[7:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clr_redirect();
    ifc.jump          = 1'b0;
    ifc.br_valid      = 1'b0;
    ifc.branch_eq     = 1'b0;
    ifc.branch_ne     = 1'b0;
    ifc.alu_zero      = 1'b0;
    ifc.br_pc_plus4   = 32'h0;
    ifc.br_imm16      = 16'h0;
    ifc.jump_target26 = 26'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + 32'(i);
    clr_redirect();
    ifc.id_ready = 1'b1;
    reset = 1'b1;

    // Reset state
    step();
    step();
    chk1("rst_valid",    ifc.if_valid, 1'b0);
    chk ("rst_addr",     ifc.imem_addr, 32'h0);
    chk ("rst_instr",    ifc.if_instr, 32'h0);
    chk ("rst_pc4",      ifc.if_pc_plus4, 32'h0);
    chk ("rst_count",    ifc.fetch_count, 32'h0);
    chk1("rst_halted",   ifc.halted, 1'b0);
    chk1("rst_misalign", ifc.misaligned, 1'b0);

    // Sequential fetch
    reset = 1'b0;
    chk("seq_addr0", ifc.imem_addr, 32'h0);
    step();
    chk ("seq_addr1",  ifc.imem_addr, 32'h4);
    chk ("seq_instr0", ifc.if_instr, 32'h2000_0000);
    chk ("seq_pc4_0",  ifc.if_pc_plus4, 32'h4);
    chk1("seq_valid0", ifc.if_valid, 1'b1);
    step();
    chk("seq_addr2",  ifc.imem_addr, 32'h8);
    chk("seq_instr1", ifc.if_instr, 32'h2000_0001);
    step();
    chk("seq_addr3",  ifc.imem_addr, 32'hC);
    chk("seq_instr2", ifc.if_instr, 32'h2000_0002);
    step();
    chk("seq_instr3", ifc.if_instr, 32'h2000_0003);
    chk("seq_pc4_3",  ifc.if_pc_plus4, 32'h10);
    chk("seq_count3", ifc.fetch_count, 32'd3);
    step();
    chk("seq_count4", ifc.fetch_count, 32'd4);
    chk("seq_instr4", ifc.if_instr, 32'h2000_0004);

    // Backpressure
    ifc.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk ("bp_instr", ifc.if_instr, 32'h2000_0004);
      chk ("bp_pc4",   ifc.if_pc_plus4, 32'h14);
      chk ("bp_addr",  ifc.imem_addr, 32'h14);
      chk ("bp_count", ifc.fetch_count, 32'd4);
      chk1("bp_valid", ifc.if_valid, 1'b1);
    end
    ifc.id_ready = 1'b1;
    step();
    chk("bp_resume_instr", ifc.if_instr, 32'h2000_0005);
    chk("bp_resume_pc4",   ifc.if_pc_plus4, 32'h18);
    chk("bp_resume_count", ifc.fetch_count, 32'd5);

    // beq taken: 0x10 + (-2 << 2) = 0x8
    ifc.br_valid    = 1'b1;
    ifc.branch_eq   = 1'b1;
    ifc.alu_zero    = 1'b1;
    ifc.br_pc_plus4 = 32'h10;
    ifc.br_imm16    = 16'hFFFE;
    step();
    chk ("beq_addr",  ifc.imem_addr, 32'h8);
    chk1("beq_flush", ifc.if_valid, 1'b0);
    chk ("beq_count", ifc.fetch_count, 32'd6);
    clr_redirect();
    step();
    chk1("beq_valid", ifc.if_valid, 1'b1);
    chk ("beq_pc4",   ifc.if_pc_plus4, 32'hC);
    chk ("beq_instr", ifc.if_instr, 32'h2000_0002);
    chk ("beq_count2", ifc.fetch_count, 32'd6);

    // beq not taken
    ifc.br_valid    = 1'b1;
    ifc.branch_eq   = 1'b1;
    ifc.alu_zero    = 1'b0;
    ifc.br_pc_plus4 = 32'h10;
    ifc.br_imm16    = 16'hFFFE;
    step();
    chk ("bnt_addr",  ifc.imem_addr, 32'h10);
    chk1("bnt_valid", ifc.if_valid, 1'b1);
    chk ("bnt_instr", ifc.if_instr, 32'h2000_0003);
    clr_redirect();

    // Jump vs branch collision: jump wins
    ifc.jump          = 1'b1;
    ifc.br_valid      = 1'b1;
    ifc.branch_ne     = 1'b1;
    ifc.alu_zero      = 1'b0;
    ifc.br_pc_plus4   = 32'h4000_0010;
    ifc.br_imm16      = 16'h0004;
    ifc.jump_target26 = 26'h40;
    step();
    chk ("coll_addr",     ifc.imem_addr, 32'h4000_0100);
    chk1("coll_flush",    ifc.if_valid, 1'b0);
    chk1("coll_misalign", ifc.misaligned, 1'b0);
    clr_redirect();

    // Misaligned base: 0x12 -> 0x10
    ifc.br_valid    = 1'b1;
    ifc.branch_eq   = 1'b1;
    ifc.alu_zero    = 1'b1;
    ifc.br_pc_plus4 = 32'h12;
    ifc.br_imm16    = 16'h0;
    step();
    chk ("mis_addr", ifc.imem_addr, 32'h10);
    chk1("mis_flag", ifc.misaligned, 1'b1);
    clr_redirect();
    step();
    chk1("mis_sticky", ifc.misaligned, 1'b1);
    chk ("mis_instr",  ifc.if_instr, 32'h2000_0004);

    // Halt: jump to 0 with halt word at address 8
    mem[2] = 32'hFC00_0000;
    ifc.jump = 1'b1;
    step();
    chk("halt_jaddr", ifc.imem_addr, 32'h0);
    clr_redirect();
    step();
    chk("halt_w0", ifc.if_instr, 32'h2000_0000);
    step();
    chk ("halt_w1",    ifc.if_instr, 32'h2000_0001);
    chk1("halt_w1v",   ifc.if_valid, 1'b1);
    chk ("halt_addr8", ifc.imem_addr, 32'h8);
    for (int i = 0; i < 10; i++) begin
      step();
      chk ("halt_addr",   ifc.imem_addr, 32'h8);
      chk1("halt_flag",   ifc.halted, 1'b1);
      chk1("halt_valid",  ifc.if_valid, 1'b0);
    end
    // Jump out of halt to 0x20
    ifc.jump          = 1'b1;
    ifc.jump_target26 = 26'h8;
    step();
    chk1("unhalt_flag", ifc.halted, 1'b0);
    chk ("unhalt_addr", ifc.imem_addr, 32'h20);
    clr_redirect();
    step();
    chk1("unhalt_valid", ifc.if_valid, 1'b1);
    chk ("unhalt_instr", ifc.if_instr, 32'h2000_0008);
    chk ("unhalt_pc4",   ifc.if_pc_plus4, 32'h24);

    // PC wrap FFFF_FFFC -> 0
    ifc.jump          = 1'b1;
    ifc.br_pc_plus4   = 32'hF000_0000;
    ifc.jump_target26 = 26'h3FF_FFFF;
    step();
    chk("wrap_addr_hi", ifc.imem_addr, 32'hFFFF_FFFC);
    clr_redirect();
    step();
    chk("wrap_addr0", ifc.imem_addr, 32'h0);
    chk("wrap_pc4",   ifc.if_pc_plus4, 32'h0);
    chk("wrap_instr", ifc.if_instr, 32'h2000_003F);

    // Reset mid-stall with a take presented
    ifc.id_ready      = 1'b0;
    ifc.jump          = 1'b1;
    ifc.jump_target26 = 26'h10;
    reset = 1'b1;
    step();
    chk1("mrst_valid",    ifc.if_valid, 1'b0);
    chk ("mrst_addr",     ifc.imem_addr, 32'h0);
    chk ("mrst_instr",    ifc.if_instr, 32'h0);
    chk ("mrst_pc4",      ifc.if_pc_plus4, 32'h0);
    chk ("mrst_count",    ifc.fetch_count, 32'h0);
    chk1("mrst_halted",   ifc.halted, 1'b0);
    chk1("mrst_misalign", ifc.misaligned, 1'b0);
    reset = 1'b0;
    clr_redirect();
    ifc.id_ready = 1'b1;
    mem[2] = 32'h2000_0002;
    step();
    chk1("post_valid", ifc.if_valid, 1'b1);
    chk ("post_instr", ifc.if_instr, 32'h2000_0000);
    chk ("post_addr",  ifc.imem_addr, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the program counter, drives the word address into the combinational instruction memory, and registers the returned word.
- Hands each fetched instruction to the decode/control stage over a valid/ready handshake.
- Applies branch (beq/bne) and jump redirects from execute, flushing the fetched slot.
- Stops fetching on a halt opcode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, instr[31:26] value that stops fetch.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- imem_addr  out  32  byte address to instruction memory; combinational copy of the PC register
- imem_rdata  in  32  instruction word; combinational from imem_addr, same cycle
- if_instr  out  32  registered instruction to decode/control
- if_pc_plus4  out  32  registered PC+4 of if_instr
- if_valid  out  1  if_instr is valid
- id_ready  in  1  decode accepts the word this cycle
- br_valid  in  1  execute presents a resolved branch
- branch_eq  in  1  branch is beq
- branch_ne  in  1  branch is bne
- alu_zero  in  1  ALU zero flag for that branch
- br_pc_plus4  in  32  PC+4 of the branch/jump instruction
- br_imm16  in  16  branch offset, in words
- jump  in  1  unconditional jump redirect
- jump_target26  in  26  jump index field
- halted  out  1  fetch stopped by halt opcode
- misaligned  out  1  sticky: a redirect target had nonzero low bits
- fetch_count  out  32  handshakes completed (if_valid & id_ready)

Behaviour:
- Clock is clk. Reset is synchronous, active-high, on port reset.
- Reset values (reset has priority over every other event, including mid-stall and mid-redirect):
  - pc = RESET_PC; state = RUN
  - if_instr = 0; if_pc_plus4 = 0; if_valid = 0
  - halted = 0; misaligned = 0; fetch_count = 0
- States:
  - RUN: fetching.
  - HALTED: PC frozen, no loads; halted = 1.
- Redirect decode: take = jump | (br_valid & ((branch_eq & alu_zero) | (branch_ne & ~alu_zero))).
- Targets:
  - Jump target = {br_pc_plus4[31:28], jump_target26, 2'b00}.
  - Branch target = br_pc_plus4 + (sign_extend(br_imm16) << 2), modulo 2^32.
  - jump has priority when jump and br_valid are both high.
  - If br_pc_plus4[1:0] != 0, force target[1:0] = 0 and set misaligned (sticky until reset).
- Per-edge priority, highest first: reset > take > load > hold.
  - take (any state): pc <= target; if_valid <= 0 (flushes the slot even if id_ready is high that cycle); state <= RUN; halted <= 0. fetch_count still counts that cycle's handshake if one occurred.
  - load (RUN, no take, and (!if_valid | id_ready)):
    - Normal opcode: if_instr <= imem_rdata; if_pc_plus4 <= pc+4; if_valid <= 1; pc <= pc+4.
    - imem_rdata[31:26] == HALT_OPCODE: word is dropped; if_valid <= 0; pc holds at the halt address; state <= HALTED.
  - hold (if_valid & !id_ready): if_instr, if_pc_plus4, if_valid and pc unchanged. if_instr must be stable while if_valid & !id_ready.
- br_valid with a not-taken condition: no effect.
- branch_eq and branch_ne both high: treated as the OR of the two terms, so the branch is always taken.
- Latency:
  - First if_valid one cycle after reset deasserts.
  - Sustained throughput 1 instruction/cycle while id_ready = 1.
  - Redirect bubble: 1 cycle (if_valid = 0), then the target instruction.
- pc wraps 32'hFFFF_FFFC -> 0 with no error.
- fetch_count increments on every edge with if_valid & id_ready (unless reset); wraps modulo 2^32.

Decomposition:
- Shared package mips_pkg: HALT_OPCODE, OPCODE_BEQ = 6'b000100, OPCODE_BNE = 6'b000101, OPCODE_J = 6'b000010, WORD_BYTES = 4, fsm enum {RUN, HALTED}.
- Optional sub-module pc_target_calc: combinational take/target/misaligned logic, so the bench can check it in isolation.

Test Plan:
- Sequential fetch:
  - Setup: reset 2 cycles, id_ready = 1, memory word i = 32'h2000_0000 + i.
  - Cycles 1..4 after reset: imem_addr = 0, 4, 8, 12.
  - Cycles 2..5: if_instr = 32'h2000_0000..32'h2000_0003, if_pc_plus4 = 4..16.
  - fetch_count = 4 after cycle 5.
- Backpressure:
  - Stimulus: id_ready = 0 for 3 cycles while if_valid = 1.
  - Response: if_instr, if_pc_plus4 and imem_addr frozen; fetch_count unchanged; resumes with no lost or duplicated word.
- beq taken:
  - Stimulus: br_valid = 1, branch_eq = 1, alu_zero = 1, br_pc_plus4 = 32'h10, br_imm16 = 16'hFFFE.
  - Response: next cycle imem_addr = 32'h8 and if_valid = 0; following cycle if_pc_plus4 = 32'hC.
  - Same stimulus with alu_zero = 0: no redirect.
- Jump vs branch collision:
  - Stimulus: jump = 1, br_valid = 1, branch_ne = 1, alu_zero = 0, br_pc_plus4 = 32'h4000_0010, jump_target26 = 26'h40.
  - Response: pc = 32'h4000_0100 (jump wins).
  - Misaligned case: br_pc_plus4 = 32'h12, branch taken with br_imm16 = 0 -> target 32'h10, misaligned = 1, stays 1 until reset.
- Halt:
  - Stimulus: word FC00_0000 at address 8.
  - Response: if_valid = 0 after the word at address 4 drains; halted = 1; imem_addr stuck at 8 for 10 cycles.
  - A jump redirect then clears halted and fetch resumes at the target.
- Reset mid-operation:
  - Stimulus: assert reset while if_valid = 1, id_ready = 0, and a take is presented in the same cycle.
  - Response: all outputs take their reset values next edge; pc = RESET_PC.
